vga_pixel_counter: RTL and testbench

Timing-generation stage that sits directly upstream of the VGA sync decoder. It divides the system clock down to the pixel rate and produces the free-running horizontal/vertical scan counters consumed by the sync decoder and the pixel/object renderers. It also emits line, frame and vertical-blank strobes, so the paddle/ball game logic updates once per frame during blanking. A frame counter is provided for animation timing.

---
 rtl/vga_pixel_counter.sv | 119 +++++++++++
 tb/tb_vga_pixel_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_counter.sv
// ---------------------------------------------------------------------------
// vga_pixel_counter
//
// Timing-generation stage that feeds the VGA sync decoder. It divides the
// system clock down to the pixel rate. It also keeps the free-running
// horizontal and vertical scan counters, emits line, frame and vertical-blank
// strobes, and counts completed frames for animation timing.
//
// Parameters:
//   CLK_DIV  system clocks per pixel (1..16)
//   H_TOTAL  pixels per line, including blanking
//   V_TOTAL  lines per frame, including blanking
//   VD       visible lines; index of the first blank line
//   FRAME_W  width of frame_count
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset (wins over enable)
//   enable       count enable; low freezes all timing state
//   pixel_tick   one-clk strobe at the pixel rate
//   h_count      horizontal position, 0..H_TOTAL-1
//   v_count      vertical position, 0..V_TOTAL-1
//   line_end     strobe on the tick that wraps h_count
//   frame_end    strobe on the tick that wraps v_count
//   vblank_tick  strobe on the tick that moves v_count from VD-1 to VD
//   frame_count  completed-frame count, modulo 2^FRAME_W
// ---------------------------------------------------------------------------
module vga_pixel_counter #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int VD      = 480,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               pixel_tick,
  output logic [9:0]         h_count,
  output logic [9:0]         v_count,
  output logic               line_end,
  output logic               frame_end,
  output logic               vblank_tick,
  output logic [FRAME_W-1:0] frame_count
);

  // A divide-by-1 still needs a one-bit counter that stays at 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       VB_LINE  = 10'(VD - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [9:0]         h_count_q, h_count_d;
  logic [9:0]         v_count_q, v_count_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  // Strobes are decoded from the current state. They lead the counter
  // update by one edge. They are masked while reset is asserted, so a reset
  // cycle never shows a tick, even with CLK_DIV=1.
  always_comb begin
    pixel_tick  = enable && !reset && (div_cnt_q == DIV_LAST);
    line_end    = pixel_tick && (h_count_q == H_LAST);
    frame_end   = line_end && (v_count_q == V_LAST);
    vblank_tick = line_end && (v_count_q == VB_LINE);
  end

  // Next-state logic. Each counter advances only when the strobe of the
  // stage below it fires. As a result, the wrap at (H_LAST, V_LAST) clears
  // both counters and bumps frame_count on the same edge.
  always_comb begin
    // NOTE: every signal gets a hold default before any conditional update;
    // a path that leaves one unassigned would infer a latch.
    div_cnt_d     = div_cnt_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_count_d = frame_count_q;

    if (enable) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end

    if (pixel_tick) begin
      h_count_d = (h_count_q == H_LAST) ? '0 : h_count_q + 10'd1;
    end

    if (line_end) begin
      v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 10'd1;
    end

    // Free-running modulo count; the natural overflow is the wrap.
    if (frame_end) begin
      frame_count_d = frame_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop
    // samples its pre-edge value regardless of statement order.
    if (reset) begin
      div_cnt_q     <= '0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      frame_count_q <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pixel_counter.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_counter
//
// Three instances share clk/reset/enable:
//   c : default geometry (CLK_DIV=4, 800x525, VD=480, 16-bit frame count)
//   a : small geometry (CLK_DIV=3, 20x12, VD=9, 3-bit frame count), so
//       frame_count wraps several times within a short run
//   b : CLK_DIV=1 with a tiny 8x5 frame (VD=3, 2-bit frame count)
// The reference model counts enabled, non-reset clocks since the last reset.
// It derives every output from that count with plain division and modulo.
// ---------------------------------------------------------------------------
module tb_vga_pixel_counter;

  typedef struct packed {
    logic        pt;
    logic        le;
    logic        fe;
    logic        vb;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  logic        c_pt, c_le, c_fe, c_vb;
  logic [9:0]  c_h, c_v;
  logic [15:0] c_fc;
  logic        a_pt, a_le, a_fe, a_vb;
  logic [9:0]  a_h, a_v;
  logic [2:0]  a_fc;
  logic        b_pt, b_le, b_fe, b_vb;
  logic [9:0]  b_h, b_v;
  logic [1:0]  b_fc;

  vga_pixel_counter u_c (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_tick(c_pt), .h_count(c_h), .v_count(c_v),
    .line_end(c_le), .frame_end(c_fe), .vblank_tick(c_vb),
    .frame_count(c_fc)
  );

  vga_pixel_counter #(
    .CLK_DIV(3), .H_TOTAL(20), .V_TOTAL(12), .VD(9), .FRAME_W(3)
  ) u_a (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_tick(a_pt), .h_count(a_h), .v_count(a_v),
    .line_end(a_le), .frame_end(a_fe), .vblank_tick(a_vb),
    .frame_count(a_fc)
  );

  vga_pixel_counter #(
    .CLK_DIV(1), .H_TOTAL(8), .V_TOTAL(5), .VD(3), .FRAME_W(2)
  ) u_b (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_tick(b_pt), .h_count(b_h), .v_count(b_v),
    .line_end(b_le), .frame_end(b_fe), .vblank_tick(b_vb),
    .frame_count(b_fc)
  );

  int     checks = 0;
  int     errors = 0;
  longint e      = 0;   // enabled, non-reset clocks since last reset
  obs_t   got_a, got_b, got_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs for geometry (d, ht, vt, vd, fw) after e enabled clocks.
  function automatic obs_t model(input longint cnt, input int d, input int ht,
                                 input int vt, input int vd, input int fw,
                                 input logic act);
    obs_t   m;
    longint pix    = cnt / d;
    longint lines  = pix / ht;
    longint frames = lines / vt;
    m.h  = 10'(pix % ht);
    m.v  = 10'(lines % vt);
    m.fc = 16'(frames % (longint'(1) << fw));
    m.pt = act && ((cnt % d) == longint'(d - 1));
    m.le = m.pt && (int'(m.h) == ht - 1);
    m.fe = m.le && (int'(m.v) == vt - 1);
    m.vb = m.le && (int'(m.v) == vd - 1);
    return m;
  endfunction

  task automatic compare_inst(input string name, input obs_t g, input obs_t x);
    check({name, ".pixel_tick"},  64'(g.pt), 64'(x.pt));
    check({name, ".line_end"},    64'(g.le), 64'(x.le));
    check({name, ".frame_end"},   64'(g.fe), 64'(x.fe));
    check({name, ".vblank_tick"}, 64'(g.vb), 64'(x.vb));
    check({name, ".h_count"},     64'(g.h),  64'(x.h));
    check({name, ".v_count"},     64'(g.v),  64'(x.v));
    check({name, ".frame_count"}, 64'(g.fc), 64'(x.fc));
  endtask

  // Apply inputs just after a rising edge, sample and compare on the
  // falling edge, then advance the model across the next rising edge.
  task automatic step(input logic rst, input logic en);
    logic act;
    reset  = rst;
    enable = en;
    @(negedge clk);
    act   = en && !rst;
    got_c = {c_pt, c_le, c_fe, c_vb, c_h, c_v, c_fc};
    got_a = {a_pt, a_le, a_fe, a_vb, a_h, a_v, 13'd0, a_fc};
    got_b = {b_pt, b_le, b_fe, b_vb, b_h, b_v, 14'd0, b_fc};
    compare_inst("c", got_c, model(e, 4, 800, 525, 480, 16, act));
    compare_inst("a", got_a, model(e, 3, 20, 12, 9, 3, act));
    compare_inst("b", got_b, model(e, 1, 8, 5, 3, 2, act));
    @(posedge clk);
    if (rst) e = 0;
    else if (en) e++;
    #1;
  endtask

  initial begin
    bit found;

    // Reset held for three clocks with enable high.
    reset  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    e = 0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Release: ticks at cycle indices 3, 7, 11; h_count follows each tick.
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b1);
      check("c_latency_tick", 64'(got_c.pt), 64'((i % 4) == 3));
      check("c_latency_h",    64'(got_c.h),  64'(i / 4));
    end

    // Long randomized run with enable mostly high.
    for (int i = 0; i < 8000; i++) begin
      step(1'b0, $urandom_range(0, 9) != 0);
    end

    // Freeze mid-line at h=300 with the divider at 2.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if ((e % 4) == 2 && ((e / 4) % 800) == 300) found = 1'b1;
      else step(1'b0, 1'b1);
    end
    check("c_wait_h300", 64'(found), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      check("c_frozen_h",    64'(got_c.h),  64'd300);
      check("c_frozen_tick", 64'(got_c.pt), 64'd0);
    end
    step(1'b0, 1'b1);
    check("c_resume_no_tick", 64'(got_c.pt), 64'd0);
    step(1'b0, 1'b1);
    check("c_resume_tick",    64'(got_c.pt), 64'd1);
    check("c_resume_h300",    64'(got_c.h),  64'd300);
    step(1'b0, 1'b1);
    check("c_resume_h301",    64'(got_c.h),  64'd301);

    // Mid-frame reset for one clock.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("c_after_reset_h",  64'(got_c.h),  64'd0);
    check("c_after_reset_v",  64'(got_c.v),  64'd0);
    check("c_after_reset_fc", 64'(got_c.fc), 64'd0);
    for (int i = 0; i < 500; i++) begin
      step(1'b0, $urandom_range(0, 3) != 0);
    end

    // CLK_DIV=1 instance: a full 8x5 frame is exactly 40 clocks.
    step(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, 1'b1);
      if (got_b.fe) begin
        found = 1'b1;
        check("b_frame_clks", 64'(i + 1), 64'd40);
      end
    end
    if (!found) check("b_frame_timeout", 64'd0, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
